// File: rtl/clk_gen_pkg.sv
// Shared constants and parameter helpers for the DAC clock-enable generator.
// Stage indices name the default 49.152 MHz / 2^(3+k) output rates.
package clk_gen_pkg;

  localparam int unsigned MCLK_HZ = 49_152_000;

  typedef enum int unsigned {
    STG_6M144 = 0,
    STG_3M072 = 1,
    STG_1M536 = 2,
    STG_768K  = 3,
    STG_384K  = 4,
    STG_192K  = 5,
    STG_96K   = 6,
    STG_48K   = 7
  } stg_idx_e;

  function automatic int calc_nstg(input int cnt_w, input int pre_w);
    return cnt_w - pre_w + 1;
  endfunction

  function automatic int calc_sel_w(input int nstg);
    return (nstg > 2) ? $clog2(nstg) : 1;
  endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// Control/strobe bundle between the clock-enable generator and its consumers.
// The slave modport is the generator side.
interface clk_enable_gen_if
  import clk_gen_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int PRE_W  = 3,
  parameter int NUM_CH = 4
);
  localparam int NSTG  = calc_nstg(CNT_W, PRE_W);
  localparam int SEL_W = calc_sel_w(NSTG);

  logic                    run;
  logic                    sync_req;
  logic                    sync_ack;
  logic [NUM_CH*SEL_W-1:0] ch_sel;
  logic [NSTG-1:0]         stg_en;
  logic [NSTG-1:0]         stg_neg_en;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       ch_neg_en;
  logic [NUM_CH-1:0]       ch_clk;
  logic                    frame_en;
  logic [CNT_W-1:0]        cnt;

  modport master (
    output run, sync_req, ch_sel,
    input  sync_ack, stg_en, stg_neg_en, ch_en, ch_neg_en, ch_clk, frame_en, cnt
  );

  modport slave (
    input  run, sync_req, ch_sel,
    output sync_ack, stg_en, stg_neg_en, ch_en, ch_neg_en, ch_clk, frame_en, cnt
  );

endinterface

// File: rtl/clk_enable_chan.sv
// One selectable output channel: boundary-loaded stage select, clamp,
// strobe mux and the registered 50% duty square wave.
module clk_enable_chan
  import clk_gen_pkg::*;
#(
  parameter int NSTG  = 8,
  parameter int SEL_W = calc_sel_w(NSTG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             sync,
  input  logic [SEL_W-1:0] sel,
  input  logic [NSTG-1:0]  stg_en,
  input  logic [NSTG-1:0]  stg_neg_en,
  output logic             ch_en,
  output logic             ch_neg_en,
  output logic             ch_clk
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NSTG - 1);

  logic [SEL_W-1:0] sel_clamped;
  logic [SEL_W-1:0] act_sel;

  assign sel_clamped = (sel > SEL_MAX) ? SEL_MAX : sel;
  assign ch_en       = stg_en[act_sel];
  assign ch_neg_en   = stg_neg_en[act_sel];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_sel <= '0;
      ch_clk  <= 1'b0;
    end else begin
      if (load) act_sel <= sel_clamped;
      // A restart or a rate change starts the square wave from low.
      if (sync || (load && (sel_clamped != act_sel))) ch_clk <= 1'b0;
      else if (ch_en)                                 ch_clk <= 1'b1;
      else if (ch_neg_en)                             ch_clk <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Power-of-two clock-enable generator: free-running counter, per-stage
// posedge/negedge strobe decode, frame strobe, restart handshake, channels.
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int PRE_W  = 3,
  parameter int NUM_CH = 4
) (
  input logic             clk,
  input logic             rst_n,
  clk_enable_gen_if.slave bus
);

  localparam int NSTG  = calc_nstg(CNT_W, PRE_W);
  localparam int SEL_W = calc_sel_w(NSTG);
  localparam logic [PRE_W-1:0] L_POS = PRE_W'((1 << (PRE_W - 1)) - 1);
  localparam logic [PRE_W-1:0] L_NEG = '1;
  localparam logic [NSTG-1:0]  ONES  = '1;

  logic [CNT_W-1:0]  cnt_q;
  logic              sync_ack_q;
  logic [NSTG-1:0]   hi;
  logic [NSTG-1:0]   stg_en;
  logic [NSTG-1:0]   stg_neg_en;
  logic              phase_pos;
  logic              phase_neg;
  logic              frame_en;
  logic              load;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_neg_en;
  logic [NUM_CH-1:0] ch_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sync_ack_q <= 1'b0;
    end else begin
      sync_ack_q <= bus.sync_req;
      if (bus.sync_req) cnt_q <= '0;
      else if (bus.run) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Upper counter bits; one spare zero bit keeps the width valid when NSTG==1.
  assign hi        = NSTG'(cnt_q >> PRE_W);
  assign phase_pos = bus.run && (cnt_q[PRE_W-1:0] == L_POS);
  assign phase_neg = bus.run && (cnt_q[PRE_W-1:0] == L_NEG);
  assign frame_en  = bus.run && (&cnt_q);
  assign load      = frame_en || bus.sync_req;

  // NOTE: defaults assigned first so the decode cannot infer a latch.
  always_comb begin
    stg_en        = '0;
    stg_neg_en    = '0;
    stg_en[0]     = phase_pos;
    stg_neg_en[0] = phase_neg;
    for (int k = 1; k < NSTG; k++) begin
      stg_en[k]     = phase_pos && ((hi & ~(ONES << k)) == '0);
      stg_neg_en[k] = phase_pos && ((hi & ~(ONES << (k - 1))) == '0) && hi[k-1];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_enable_chan #(
      .NSTG  (NSTG),
      .SEL_W (SEL_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .sync       (bus.sync_req),
      .sel        (bus.ch_sel[i*SEL_W +: SEL_W]),
      .stg_en     (stg_en),
      .stg_neg_en (stg_neg_en),
      .ch_en      (ch_en[i]),
      .ch_neg_en  (ch_neg_en[i]),
      .ch_clk     (ch_clk[i])
    );
  end

  assign bus.cnt        = cnt_q;
  assign bus.sync_ack   = sync_ack_q;
  assign bus.stg_en     = stg_en;
  assign bus.stg_neg_en = stg_neg_en;
  assign bus.frame_en   = frame_en;
  assign bus.ch_en      = ch_en;
  assign bus.ch_neg_en  = ch_neg_en;
  assign bus.ch_clk     = ch_clk;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench: default instance (CNT_W=10, PRE_W=3, 4 channels) and a
// small NSTG=5 instance exercising select clamping.
module tb_clk_enable_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  clk_enable_gen_if #(.CNT_W(10), .PRE_W(3), .NUM_CH(4)) bus_a ();
  clk_enable_gen_if #(.CNT_W(7),  .PRE_W(3), .NUM_CH(1)) bus_b ();

  clk_enable_gen #(.CNT_W(10), .PRE_W(3), .NUM_CH(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  clk_enable_gen #(.CNT_W(7), .PRE_W(3), .NUM_CH(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_a(input int target);
    int guard = 0;
    while (int'(bus_a.cnt) != target && guard < 2100) begin
      tick(1);
      guard++;
    end
    check($sformatf("reach_a_%0d", target), 32'(bus_a.cnt), 32'(target));
  endtask

  task automatic wait_b(input int target);
    int guard = 0;
    while (int'(bus_b.cnt) != target && guard < 300) begin
      tick(1);
      guard++;
    end
    check($sformatf("reach_b_%0d", target), 32'(bus_b.cnt), 32'(target));
  endtask

  initial begin
    int c0, c7, cn7, cf;
    rst_n          = 1'b0;
    bus_a.run      = 1'b1;
    bus_a.sync_req = 1'b0;
    bus_a.ch_sel   = {3'd2, 3'd7, 3'd5, 3'd0};
    bus_b.run      = 1'b1;
    bus_b.sync_req = 1'b0;
    bus_b.ch_sel   = 3'd7;
    #22;

    // Reset state
    check("rst_cnt",      32'(bus_a.cnt), 0);
    check("rst_ack",      32'(bus_a.sync_ack), 0);
    check("rst_ch_clk",   32'(bus_a.ch_clk), 0);
    check("rst_stg_en",   32'(bus_a.stg_en), 0);
    check("rst_stg_neg",  32'(bus_a.stg_neg_en), 0);
    check("rst_frame",    32'(bus_a.frame_en), 0);
    rst_n = 1'b1;

    // First strobe H=3 cycles after release; all stages align at cnt=3
    tick(2);
    check("cnt2",         32'(bus_a.cnt), 2);
    check("cnt2_stg",     32'(bus_a.stg_en), 0);
    tick(1);
    check("cnt3_stg",     32'(bus_a.stg_en), 32'hFF);
    check("cnt3_ch_en",   32'(bus_a.ch_en), 32'hF);
    tick(1);
    check("cnt4_ch_clk",  32'(bus_a.ch_clk), 32'hF);
    check("cnt4_stg",     32'(bus_a.stg_en), 0);
    wait_a(7);
    check("cnt7_neg",     32'(bus_a.stg_neg_en), 32'h01);
    check("cnt7_ch_neg",  32'(bus_a.ch_neg_en), 32'hF);
    tick(1);
    check("cnt8_ch_clk",  32'(bus_a.ch_clk), 0);
    wait_a(11);
    check("cnt11_stg",    32'(bus_a.stg_en), 32'h01);
    check("cnt11_neg",    32'(bus_a.stg_neg_en), 32'h02);

    // Full-frame strobe counts
    wait_a(0);
    c0 = 0; c7 = 0; cn7 = 0; cf = 0;
    for (int i = 0; i < 1024; i++) begin
      if (bus_a.stg_en[0])     c0++;
      if (bus_a.stg_en[7])     c7++;
      if (bus_a.stg_neg_en[7]) cn7++;
      if (bus_a.frame_en)      cf++;
      tick(1);
    end
    check("frame_cnt_stg0",  32'(c0), 128);
    check("frame_cnt_stg7",  32'(c7), 1);
    check("frame_cnt_neg7",  32'(cn7), 1);
    check("frame_cnt_frame", 32'(cf), 1);

    // Channels running with selects {2,7,5,0}
    wait_a(3);
    check("f2_cnt3_ch_en",    32'(bus_a.ch_en), 32'hF);
    tick(1);
    check("f2_cnt4_ch_clk",   32'(bus_a.ch_clk), 32'hF);
    wait_a(130);
    check("f2_cnt130_ch_clk", 32'(bus_a.ch_clk), 32'b0110);
    tick(1);
    check("f2_cnt131_ch_neg", 32'(bus_a.ch_neg_en), 32'b0010);
    check("f2_cnt131_ch_en",  32'(bus_a.ch_en), 32'b1001);
    tick(1);
    check("f2_cnt132_ch_clk", 32'(bus_a.ch_clk), 32'b1101);
    wait_a(258);
    check("f2_cnt258_ch_en",  32'(bus_a.ch_en), 0);
    tick(1);
    check("f2_cnt259_ch_en",  32'(bus_a.ch_en), 32'b1011);

    // Select change mid-frame takes effect only at the frame boundary
    wait_a(500);
    bus_a.ch_sel = {3'd2, 3'd7, 3'd5, 3'd3};
    wait_a(507);
    check("chg_cnt507_ch_en",  32'(bus_a.ch_en), 32'b0001);
    wait_a(515);
    check("chg_cnt515_ch_neg", 32'(bus_a.ch_neg_en), 32'b0100);
    check("chg_cnt515_stgneg", 32'(bus_a.stg_neg_en), 32'h80);
    wait_a(1023);
    check("chg_cnt1023_frame", 32'(bus_a.frame_en), 1);
    check("chg_cnt1023_chneg", 32'(bus_a.ch_neg_en), 32'b0001);
    tick(1);
    check("chg_cnt0_ch_clk",   32'(bus_a.ch_clk), 0);
    wait_a(3);
    check("chg_cnt3_ch_en",    32'(bus_a.ch_en), 32'hF);
    wait_a(11);
    check("chg_cnt11_ch_en",   32'(bus_a.ch_en), 0);
    wait_a(35);
    check("chg_cnt35_ch_neg",  32'(bus_a.ch_neg_en), 32'b0001);
    wait_a(67);
    check("chg_cnt67_ch_en",   32'(bus_a.ch_en), 32'b1001);

    // Sync pulse mid-frame
    wait_a(600);
    check("sync_pre_ch_clk", 32'(bus_a.ch_clk[1]), 1);
    bus_a.ch_sel   = {3'd2, 3'd7, 3'd5, 3'd1};
    bus_a.sync_req = 1'b1;
    tick(1);
    bus_a.sync_req = 1'b0;
    check("sync_cnt",        32'(bus_a.cnt), 0);
    check("sync_ack",        32'(bus_a.sync_ack), 1);
    check("sync_ch_clk",     32'(bus_a.ch_clk), 0);
    tick(1);
    check("sync_cnt1",       32'(bus_a.cnt), 1);
    check("sync_ack_drop",   32'(bus_a.sync_ack), 0);
    wait_a(11);
    check("sync_cnt11_neg",  32'(bus_a.ch_neg_en), 32'b0001);
    check("sync_cnt11_en",   32'(bus_a.ch_en), 0);

    // Sync coinciding with the frame strobe
    wait_a(1023);
    bus_a.ch_sel   = {3'd2, 3'd7, 3'd5, 3'd0};
    bus_a.sync_req = 1'b1;
    #1;
    check("fsync_frame",     32'(bus_a.frame_en), 1);
    tick(1);
    bus_a.sync_req = 1'b0;
    check("fsync_cnt",       32'(bus_a.cnt), 0);
    check("fsync_ack",       32'(bus_a.sync_ack), 1);
    check("fsync_ch_clk",    32'(bus_a.ch_clk), 0);
    wait_a(7);
    check("fsync_cnt7_neg",  32'(bus_a.ch_neg_en), 32'b0001);

    // run=0 hold and gating
    wait_a(10);
    bus_a.run = 1'b0;
    tick(20);
    check("hold_cnt",        32'(bus_a.cnt), 10);
    check("hold_stg",        32'(bus_a.stg_en), 0);
    check("hold_frame",      32'(bus_a.frame_en), 0);
    bus_a.run = 1'b1;
    tick(1);
    check("resume_cnt",      32'(bus_a.cnt), 11);
    check("resume_stg",      32'(bus_a.stg_en), 32'h01);
    check("resume_neg",      32'(bus_a.stg_neg_en), 32'h02);
    bus_a.run = 1'b0;
    #1;
    check("gate_stg",        32'(bus_a.stg_en), 0);
    check("gate_neg",        32'(bus_a.stg_neg_en), 0);

    // Sync held two cycles, first while stopped
    bus_a.sync_req = 1'b1;
    tick(1);
    check("hsync1_cnt",      32'(bus_a.cnt), 0);
    check("hsync1_ack",      32'(bus_a.sync_ack), 1);
    bus_a.run = 1'b1;
    tick(1);
    check("hsync2_cnt",      32'(bus_a.cnt), 0);
    check("hsync2_ack",      32'(bus_a.sync_ack), 1);
    bus_a.sync_req = 1'b0;
    tick(1);
    check("hsync_end_cnt",   32'(bus_a.cnt), 1);
    check("hsync_end_ack",   32'(bus_a.sync_ack), 0);

    // Out-of-range select clamps to stage 4 (period 128) on the NSTG=5 instance
    bus_b.sync_req = 1'b1;
    tick(1);
    bus_b.sync_req = 1'b0;
    check("b_sync_cnt",      32'(bus_b.cnt), 0);
    check("b_sync_ack",      32'(bus_b.sync_ack), 1);
    wait_b(3);
    check("b_cnt3_en",       32'(bus_b.ch_en), 1);
    tick(1);
    check("b_cnt4_clk",      32'(bus_b.ch_clk), 1);
    wait_b(19);
    check("b_cnt19_en",      32'(bus_b.ch_en), 0);
    wait_b(35);
    check("b_cnt35_en",      32'(bus_b.ch_en), 0);
    wait_b(67);
    check("b_cnt67_neg",     32'(bus_b.ch_neg_en), 1);
    tick(1);
    check("b_cnt68_clk",     32'(bus_b.ch_clk), 0);
    wait_b(127);
    check("b_cnt127_frame",  32'(bus_b.frame_en), 1);
    tick(1);
    check("b_wrap_cnt",      32'(bus_b.cnt), 0);
    tick(3);
    check("b_cnt3b_en",      32'(bus_b.ch_en), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Parametrised clock-enable generator for the DAC datapath. It derives power-of-two strobe enables from the 49.152 MHz master clock: one posedge strobe and one negedge strobe per division stage. It also provides NUM_CH independently selectable output channels, each carrying its own strobes and a 50% duty registered square wave. Channel rate changes take effect only at frame boundaries, and a synchronous restart handshake realigns all channels.

## Interface
- CNT_W, 10, free-running counter width; the slowest stage period is 2^CNT_W clk.
- PRE_W, 3, base prescale exponent; stage 0 period is 2^PRE_W clk. Range 2..CNT_W.
- NUM_CH, 4, number of selectable output channels. Must be ≥1.
- Derived, not overridable:
  - NSTG = CNT_W-PRE_W+1, number of stages.
  - SEL_W = max(1, clog2(NSTG)).
- clk  in  1  master clock (49.152 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  counter advance enable; when low, the counter holds and no strobes are asserted.
- sync_req  in  1  one-cycle request to restart the counter and channels.
- sync_ack  out  1  one-cycle acknowledge of sync_req.
- ch_sel  in  NUM_CH*SEL_W  stage select per channel; channel i uses bits [i*SEL_W +: SEL_W].
- stg_en  out  NSTG  per-stage posedge strobes.
- stg_neg_en  out  NSTG  per-stage negedge strobes.
- ch_en  out  NUM_CH  channel posedge strobe.
- ch_neg_en  out  NUM_CH  channel negedge strobe.
- ch_clk  out  NUM_CH  channel square wave, registered.
- frame_en  out  1  strobe in the cycle when cnt is all-ones and run=1.
- cnt  out  CNT_W  free-running counter value.

## Operation
- Counter:
  - cnt increments by 1 modulo 2^CNT_W on each clk where run=1.
  - cnt wraps from all-ones to 0 with no gap.
- Definitions: L = cnt[PRE_W-1:0]; H = 2^(PRE_W-1)-1.
- Stage 0:
  - stg_en[0] = run && L==H.
  - stg_neg_en[0] = run && L==2^PRE_W-1.
- Stage k≥1:
  - stg_en[k] = run && L==H && cnt[PRE_W+k-1:PRE_W]==0.
  - stg_neg_en[k] = run && L==H && cnt[PRE_W+k-2:PRE_W]==0 && cnt[PRE_W+k-1]==1.
  - Period is 2^(PRE_W+k). The negedge strobe falls exactly half a period after the posedge strobe.
- Stage strobes are combinational decodes of the registered cnt. Each strobe is high for exactly one cycle.
- Channels:
  - Each channel has an active select register act_sel[i].
  - ch_en[i] = stg_en[act_sel[i]] and ch_neg_en[i] = stg_neg_en[act_sel[i]].
  - A select value ≥ NSTG is clamped to NSTG-1.
- Select update:
  - ch_sel is sampled into act_sel on a frame_en cycle or a sync_req cycle.
  - Changes of ch_sel at any other time have no effect until the next boundary.
  - When act_sel[i] changes at a boundary, ch_clk[i] is cleared in the same update.
- ch_clk[i]:
  - Set the cycle after ch_en[i] and cleared the cycle after ch_neg_en[i].
  - Result: 50% duty, lagging the strobes by one clk.
- Sync:
  - When sync_req=1 at a clk edge: cnt becomes 0, all ch_clk become 0, act_sel loads ch_sel, and sync_ack=1 for that following cycle.
  - sync_req is honoured regardless of run.
  - A sync_req held high for N cycles restarts the counter on each of those cycles and produces N acks.
- Simultaneous events:
  - If sync_req coincides with frame_en, sync takes precedence; the result is identical to sync alone.
  - If ch_en and ch_neg_en for the same channel coincide (impossible for valid parameters), set wins.

## Timing
- Reset values:
  - cnt=0, act_sel=0, ch_clk=0, sync_ack=0.
  - Strobes are decoded from cnt=0: all low for PRE_W≥2.
- The first stg_en[0] asserts H clk cycles after reset release when run=1.
- Strobe latency from cnt: 0 cycles (combinational).
- ch_clk latency: 1 cycle after the strobe.
- sync_ack latency: 1 cycle after sync_req.
- Select change latency: at most 2^CNT_W cycles (the next frame_en).
- If reset asserts mid-frame, all state returns to reset values immediately (asynchronous). Operation resumes from cnt=0.

## Structure
- A shared package clk_gen_pkg holds:
  - the function computing NSTG/SEL_W;
  - the 49.152 MHz frequency constant;
  - named stage indices for the defaults (STG_6M144=0 through STG_48K=7).
- One sub-module, clk_enable_chan, is instantiated NUM_CH times. It contains act_sel, the strobe mux, the clamp and the ch_clk register.
- The top level holds the counter, the stage decode, frame_en and the sync logic.

## Test plan
- Reset with default parameters, run=1, sel=0:
  - stg_en[0] at cnt=3,11,19,…; stg_neg_en[0] at cnt=7,15,…
  - stg_en[7] only at cnt=3, once per 1024 cycles.
- Channel 1 sel=5 (192 kHz):
  - ch_en every 256 clk at cnt=3 and 259; ch_neg_en at cnt=131 and 387.
  - ch_clk is high for 128 cycles starting at cnt=4.
- Change ch_sel[0] from 0 to 3 at cnt=500:
  - stage-0 behaviour continues until cnt=1023.
  - act_sel=3 from cnt=0; ch_clk[0] cleared there; next ch_en[0] at cnt=3 and then every 64 clk.
- sync_req pulse at cnt=600:
  - next cycle cnt=0, sync_ack=1, all ch_clk=0, new ch_sel applied.
  - Coinciding sync_req with cnt=1023 gives the same result.
- run=0 for 20 cycles at cnt=10: cnt holds at 10, no strobes; the counter resumes at 11.
- ch_sel=7 with NSTG=8, then ch_sel out of range using NSTG=5 (CNT_W=7, PRE_W=3, sel=7): the channel behaves as stage 4, period 128.
